divu_hilo: RTL and testbench

DIVU_HILO -- requirements
Module: divu_hilo

---
 rtl/divu_hilo.sv | 110 +++++++++++
 tb/tb_divu_hilo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/divu_hilo.sv
// divu_hilo: multi-cycle unsigned 32-bit divider feeding the Hi/Lo register pair.
// A rising edge on the DIVU function code starts a restoring divide that
// produces one quotient bit per clock. Hi receives the remainder and Lo
// receives the quotient, 33 cycles after the start edge.
module divu_hilo #(
    parameter logic [5:0] DIVU = 6'b011011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  prev_sig;   // Signal as seen on the previous edge, for edge detection
    logic [31:0] dividend;   // shifts out dividend bits and shifts in quotient bits
    logic [31:0] divisor;
    logic [32:0] rem;        // partial remainder
    logic [5:0]  count;

    logic        start;
    logic        last;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        q_bit;

    // A held DIVU code must not retrigger, so only its first cycle starts a divide.
    assign start = (state == IDLE) && (Signal == DIVU) && (prev_sig != DIVU);
    assign last  = (count == 6'd31);

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        shifted = {rem[31:0], dividend[31]};
        diff    = shifted - {1'b0, divisor};
        // The remainder stays below the divisor, so a borrow shows up in bit 32.
        q_bit   = ~diff[32];
    end

    // Next-state logic; DONE always lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with synchronous reset; reset wins over a simultaneous start.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Datapath: operand capture, iteration, and Hi/Lo/flag update at the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sig    <= '0;
            dividend    <= '0;
            divisor     <= '0;
            rem         <= '0;
            count       <= '0;
            HiOut       <= '0;
            LoOut       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            prev_sig <= Signal;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend <= dataA;
                        divisor  <= dataB;
                        rem      <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    rem      <= q_bit ? diff : shifted;
                    dividend <= {dividend[30:0], q_bit};
                    count    <= count + 6'd1;
                    if (last) begin
                        HiOut       <= q_bit ? diff[31:0] : shifted[31:0];
                        LoOut       <= {dividend[30:0], q_bit};
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        div_by_zero <= (divisor == 32'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_hilo.sv
// tb_divu_hilo: directed-vector bench for divu_hilo with hand-computed results.
module tb_divu_hilo;

    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000;
    localparam logic [5:0] MFLO = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    divu_hilo #(.DIVU(DIVU)) dut (
        .clk(clk),
        .reset(reset),
        .dataA(dataA),
        .dataB(dataB),
        .Signal(Signal),
        .HiOut(HiOut),
        .LoOut(LoOut),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pulse DIVU for one cycle; returns at the negedge of cycle N+1.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = DIVU;
        @(negedge clk);
        Signal = 6'd0;
    endtask

    // Sample from cycle N+1 until done rises; lat is the cycle offset of done.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (lat <= 100) begin
            if (busy) busy_cnt++;
            if (done) break;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full divide with latency, busy-length and result checks, plus done falling.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        int lat;
        int bc;
        start_div(a, b);
        wait_done(lat, bc);
        check({tag, " latency"}, lat, 33);
        check({tag, " busy_cycles"}, bc, 32);
        check({tag, " hi"}, HiOut, hi);
        check({tag, " lo"}, LoOut, lo);
        check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, dz});
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] hi_seen;
        logic [31:0] lo_seen;

        reset  = 1'b1;
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        repeat (3) @(negedge clk);
        check("reset hi", HiOut, 32'd0);
        check("reset lo", LoOut, 32'd0);
        check("reset flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        reset = 1'b0;

        run_div("100/7", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_div("7/max", 32'd7, 32'hFFFF_FFFF, 32'd7, 32'd0, 1'b0);
        run_div("5/0", 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_div("9/3", 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        // Operand change and DIVU re-pulse mid-run are ignored.
        start_div(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        dataA  = 32'd50;
        Signal = DIVU;
        @(negedge clk);
        Signal = 6'd0;
        dones   = 0;
        hi_seen = '0;
        lo_seen = '0;
        repeat (60) begin
            if (done) begin
                dones++;
                hi_seen = HiOut;
                lo_seen = LoOut;
            end
            @(negedge clk);
        end
        check("midrun done_count", dones, 1);
        check("midrun hi", hi_seen, 32'd2);
        check("midrun lo", lo_seen, 32'd14);

        // Reset in the middle of a divide aborts it and clears Hi/Lo.
        start_div(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi", HiOut, 32'd0);
        check("abort lo", LoOut, 32'd0);
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no_done", dones, 0);

        // Reset has priority over a simultaneous start.
        dataA  = 32'd40;
        dataB  = 32'd6;
        Signal = DIVU;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        Signal = 6'd0;
        check("rst_vs_start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rst_vs_start busy2", {31'd0, busy}, 32'd0);

        // Holding DIVU for 80 cycles gives exactly one divide.
        dataA  = 32'd20;
        dataB  = 32'd6;
        Signal = DIVU;
        dones  = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("hold done_count", dones, 1);
        check("hold hi", HiOut, 32'd2);
        check("hold lo", LoOut, 32'd3);

        // Move-from codes leave Hi/Lo untouched.
        Signal = MFHI;
        dataA  = 32'd77;
        repeat (3) @(negedge clk);
        Signal = MFLO;
        repeat (3) @(negedge clk);
        Signal = 6'd0;
        @(negedge clk);
        check("mf hi", HiOut, 32'd2);
        check("mf lo", LoOut, 32'd3);
        check("mf busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
